pooling_layer_controller: RTL and testbench
===========================================

// Module: pooling_layer_controller
// PURPOSE
//  Sequences the pooling layer datapath for one feature map, row by row.
//  - Accepts conv-layer output rows over a valid/ready handshake.
//  - Pulses the input-cache capture strobe (kernel_calc_fin) and steers the max-merge accumulator.
//  - Waits out the comparator latency, then presents one pooled row per KERNEL_SIZE input rows.
//  - Signals layer completion after OUTPUT_SIZE pooled rows.
// PARAMETERS
//  INPUT_SIZE   6  elements per input row (width of cache data_in)
//  KERNEL_SIZE  2  pooling window height/width; input rows merged per output row
//  OUTPUT_SIZE  3  output rows per map (= INPUT_SIZE/KERNEL_SIZE)
//  CMP_LATENCY  2  cycles the float max-comparator needs after each capture (>=1)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  start           in   1   1-cycle pulse: begin a new map (honoured in IDLE only)
//  abort           in   1   synchronous abort, returns to IDLE
//  in_valid        in   1   upstream row available
//  in_ready        out  1   controller accepts a row this cycle
//  kernel_calc_fin out  1   cache capture strobe, 1 cycle per accepted row
//  acc_mode        out  1   0 = load accumulator with row, 1 = max-merge row into accumulator
//  cmp_busy        out  1   comparator window active
//  out_valid       out  1   pooled row valid on datapath output
//  out_ready       in   1   downstream accepts pooled row
//  out_row_idx     out  $clog2(OUTPUT_SIZE)  index of the pooled row presented
//  busy            out  1   high in any state except IDLE
//  layer_done      out  1   1-cycle pulse after the last pooled row is accepted
// BEHAVIOUR
//  - Reset: state IDLE; all counters 0; every output 0.
//  - FSM states: IDLE, WAIT_ROW, CALC, OUTPUT, DONE.
//  - IDLE: in_ready=0. start=1 clears win_row and out_row, next state WAIT_ROW.
//  - WAIT_ROW: in_ready=1.
//      - Handshake (in_valid&in_ready) drives kernel_calc_fin=1 combinationally that cycle.
//      - acc_mode = (win_row!=0) that same cycle.
//      - Next state CALC; cycle counter loads CMP_LATENCY-1.
//  - CALC: in_ready=0, cmp_busy=1. Counter decrements each cycle.
//      - At 0 with win_row==KERNEL_SIZE-1: win_row clears, next state OUTPUT.
//      - At 0 otherwise: win_row increments, next state WAIT_ROW.
//  - OUTPUT: out_valid=1 and out_row_idx=out_row, held until out_ready.
//      - On accept with out_row==OUTPUT_SIZE-1: next state DONE.
//      - On accept otherwise: out_row increments, next state WAIT_ROW.
//  - DONE: layer_done=1 for exactly one cycle, next state IDLE.
//  - Latency per pooled row: KERNEL_SIZE*(1+CMP_LATENCY)+1 cycles with no stalls.
//  - Counter widths: win_row max($clog2(KERNEL_SIZE),1); out_row $clog2(OUTPUT_SIZE);
//    cycle counter $clog2(CMP_LATENCY+1). No counter ever wraps mid-map.
//  - Boundary conditions:
//      - start outside IDLE: ignored.
//      - in_valid while in_ready=0: ignored; upstream holds the row.
//      - out_ready while out_valid=0: no effect.
//      - abort in any state: next state IDLE, counters cleared; no kernel_calc_fin,
//        out_valid or layer_done that cycle. abort wins over a simultaneous handshake.
//      - abort and start in the same cycle: abort wins, stay IDLE.
//      - rst mid-map: immediate return to reset values; cache contents don't care.
// STRUCTURE
//  - Shared pooling package:
//      - typedef enum logic[2:0] pool_state_t {IDLE,WAIT_ROW,CALC,OUTPUT,DONE}
//      - KERNEL_SIZE, INPUT_SIZE and OUTPUT_SIZE defaults (shared with cache and comparator)
//  - One sub-module: pool_latency_counter (load/decrement/zero flag), reusable by the conv controller.
//  - FSM and row counters stay in this module.
// TESTING (defaults; cycle 0 = edge where start is sampled)
//  1. start, in_valid=1, out_ready=1 continuously:
//       -> 6 kernel_calc_fin pulses; acc_mode 0,1,0,1,0,1
//       -> out_valid in cycles 7,14,21 with out_row_idx 0,1,2
//       -> layer_done in cycle 22 only; busy low from cycle 23.
//  2. in_valid low 3 cycles before row 2 -> in_ready stays 1, no strobe until in_valid; output shifts +3 cycles.
//  3. out_ready low 4 cycles at row 0 -> out_valid/out_row_idx=0 held stable; no in_ready during stall.
//  4. abort in CALC of row 3 -> IDLE next cycle; no out_valid/layer_done; new start gives full sequence as test 1.
//  5. start pulsed while busy; abort+start together in IDLE -> both ignored, no state change.
//  6. rst asserted in OUTPUT between edges -> outputs 0 immediately; post-reset start behaves as test 1.

Source files
------------

// File: rtl/pooling_layer_controller_pkg.sv
// Shared pooling-layer definitions: FSM state encoding, default geometry and a
// width helper used by the controller, the input cache and the comparator.
package pooling_layer_controller_pkg;

    localparam int INPUT_SIZE  = 6;
    localparam int KERNEL_SIZE = 2;
    localparam int OUTPUT_SIZE = INPUT_SIZE / KERNEL_SIZE;
    localparam int CMP_LATENCY = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROW,
        CALC,
        OUTPUT,
        DONE
    } pool_state_t;

    // Counter width for values 0..v-1; never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/pooling_layer_controller_if.sv
// Control/handshake bundle between the pooling controller and its neighbours.
// Signal suffixes are from the controller's point of view.
interface pooling_layer_controller_if #(
    parameter int OUT_IDX_W = 2
);
    logic                 start_i;
    logic                 abort_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 kernel_calc_fin_o;
    logic                 acc_mode_o;
    logic                 cmp_busy_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [OUT_IDX_W-1:0] out_row_idx_o;
    logic                 busy_o;
    logic                 layer_done_o;

    // Controller side.
    modport slave (
        input  start_i, abort_i, in_valid_i, out_ready_i,
        output in_ready_o, kernel_calc_fin_o, acc_mode_o, cmp_busy_o,
               out_valid_o, out_row_idx_o, busy_o, layer_done_o
    );

    // Sequencer / upstream / downstream side.
    modport master (
        output start_i, abort_i, in_valid_i, out_ready_i,
        input  in_ready_o, kernel_calc_fin_o, acc_mode_o, cmp_busy_o,
               out_valid_o, out_row_idx_o, busy_o, layer_done_o
    );

endinterface

// File: rtl/pool_latency_counter.sv
// Small down-counter that times a fixed-latency unit: load on issue,
// decrement while busy, zero flag marks the end of the latency window.
module pool_latency_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;

    // Clear beats load beats decrement; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/pooling_layer_controller.sv
// Pooling layer controller: accepts conv output rows, strobes the input cache,
// steers the max-merge accumulator, waits out the comparator and hands one
// pooled row downstream per KERNEL_SIZE input rows.
module pooling_layer_controller
    import pooling_layer_controller_pkg::*;
#(
    parameter int KERNEL_SIZE = pooling_layer_controller_pkg::KERNEL_SIZE,
    parameter int OUTPUT_SIZE = pooling_layer_controller_pkg::OUTPUT_SIZE,
    parameter int CMP_LATENCY = pooling_layer_controller_pkg::CMP_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst,
    pooling_layer_controller_if.slave   bus
);

    localparam int WIN_W = clog2_min1(KERNEL_SIZE);
    localparam int OUT_W = clog2_min1(OUTPUT_SIZE);
    localparam int CNT_W = clog2_min1(CMP_LATENCY + 1);

    pool_state_t      state_q;
    logic [WIN_W-1:0] win_row_q;
    logic [OUT_W-1:0] out_row_q;

    logic             row_hs;
    logic             row_out_acc;
    logic             win_last;
    logic             out_last;
    logic             cmp_zero;

    // A row is taken only in WAIT_ROW, and never in a cycle that is aborted.
    assign row_hs      = (state_q == WAIT_ROW) && bus.in_valid_i && !bus.abort_i;
    assign row_out_acc = (state_q == OUTPUT) && bus.out_ready_i && !bus.abort_i;
    assign win_last    = (win_row_q == WIN_W'(KERNEL_SIZE - 1));
    assign out_last    = (out_row_q == OUT_W'(OUTPUT_SIZE - 1));

    // Comparator window: loaded on capture so CALC lasts exactly CMP_LATENCY cycles.
    pool_latency_counter #(
        .CNT_W (CNT_W)
    ) u_cmp_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (bus.abort_i),
        .load_i     (row_hs),
        .load_val_i (CNT_W'(CMP_LATENCY - 1)),
        .dec_i      (state_q == CALC),
        .zero_o     (cmp_zero)
    );

    // Sequencer: state plus window-row and output-row counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            win_row_q <= '0;
            out_row_q <= '0;
        end else if (bus.abort_i) begin
            state_q   <= IDLE;
            win_row_q <= '0;
            out_row_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        win_row_q <= '0;
                        out_row_q <= '0;
                        state_q   <= WAIT_ROW;
                    end
                end
                WAIT_ROW: begin
                    if (row_hs) begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (cmp_zero) begin
                        if (win_last) begin
                            win_row_q <= '0;
                            state_q   <= OUTPUT;
                        end else begin
                            win_row_q <= win_row_q + WIN_W'(1);
                            state_q   <= WAIT_ROW;
                        end
                    end
                end
                OUTPUT: begin
                    if (row_out_acc) begin
                        if (out_last) begin
                            state_q <= DONE;
                        end else begin
                            out_row_q <= out_row_q + OUT_W'(1);
                            state_q   <= WAIT_ROW;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode the state register; abort masks anything that would
    // otherwise look like a transfer or completion in the aborted cycle.
    always_comb begin
        bus.in_ready_o        = (state_q == WAIT_ROW) && !bus.abort_i;
        bus.kernel_calc_fin_o = row_hs;
        bus.acc_mode_o        = row_hs && (win_row_q != '0);
        bus.cmp_busy_o        = (state_q == CALC);
        bus.out_valid_o       = (state_q == OUTPUT) && !bus.abort_i;
        bus.out_row_idx_o     = out_row_q;
        bus.busy_o            = (state_q != IDLE);
        bus.layer_done_o      = (state_q == DONE) && !bus.abort_i;
    end

endmodule

// File: tb/tb_pooling_layer_controller.sv
// Bench for the pooling layer controller: directed map sequences plus a
// randomized phase, all checked cycle by cycle against a timeline model that
// predicts transfers from cycle arithmetic on accepted rows.
module tb_pooling_layer_controller;
    import pooling_layer_controller_pkg::*;

    localparam int K  = KERNEL_SIZE;
    localparam int O  = OUTPUT_SIZE;
    localparam int L  = CMP_LATENCY;
    localparam int IW = clog2_min1(O);
    localparam int P  = K * (1 + L) + 1;   // cycles per pooled row, no stalls

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pooling_layer_controller_if #(.OUT_IDX_W(IW)) bus();

    pooling_layer_controller #(
        .KERNEL_SIZE (K),
        .OUTPUT_SIZE (O),
        .CMP_LATENCY (L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;

    // stimulus for the next cycle
    bit st, ab, iv, ordy;

    // reference timeline model
    bit m_active;
    int m_next_acc, m_rows, m_out_at, m_done_at, m_last_acc;

    // observations from the last stepped cycle
    bit o_kcf, o_ov, o_done, o_busy;

    // directed-run bookkeeping
    int ov_rel[$];
    int done_rel, idle_rel, kcf_cnt, stall, t0;

    task automatic check_val(input string tag, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, t);
        end
    endtask

    task automatic model_clear();
        m_active   = 1'b0;
        m_next_acc = 0;
        m_rows     = 0;
        m_out_at   = -1;
        m_done_at  = -1;
        m_last_acc = -1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_in_ready"},  bus.in_ready_o, 0);
        check_val({tag, "_kcf"},       bus.kernel_calc_fin_o, 0);
        check_val({tag, "_acc_mode"},  bus.acc_mode_o, 0);
        check_val({tag, "_cmp_busy"},  bus.cmp_busy_o, 0);
        check_val({tag, "_out_valid"}, bus.out_valid_o, 0);
        check_val({tag, "_row_idx"},   bus.out_row_idx_o, 0);
        check_val({tag, "_busy"},      bus.busy_o, 0);
        check_val({tag, "_done"},      bus.layer_done_o, 0);
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model across the coming rising edge.
    task automatic step();
        bit e_in_ready, e_kcf, e_acc, e_cmp, e_ov, e_done;
        int e_idx;
        @(negedge clk);
        bus.start_i     = st;
        bus.abort_i     = ab;
        bus.in_valid_i  = iv;
        bus.out_ready_i = ordy;
        #1;
        e_in_ready = m_active && !ab && m_out_at < 0 && m_done_at < 0 && t >= m_next_acc;
        e_kcf      = e_in_ready && iv;
        e_acc      = e_kcf && (m_rows % K != 0);
        e_cmp      = m_active && m_last_acc >= 0 && t > m_last_acc && t <= m_last_acc + L;
        e_ov       = m_active && !ab && m_out_at >= 0 && t >= m_out_at;
        e_idx      = m_rows / K - 1;
        e_done     = m_active && !ab && t == m_done_at;

        check_val("in_ready",  bus.in_ready_o, int'(e_in_ready));
        check_val("kcf",       bus.kernel_calc_fin_o, int'(e_kcf));
        check_val("acc_mode",  bus.acc_mode_o, int'(e_acc));
        check_val("cmp_busy",  bus.cmp_busy_o, int'(e_cmp));
        check_val("out_valid", bus.out_valid_o, int'(e_ov));
        if (e_ov) check_val("out_row_idx", bus.out_row_idx_o, e_idx);
        check_val("busy",      bus.busy_o, int'(m_active));
        check_val("layer_done", bus.layer_done_o, int'(e_done));

        o_kcf  = bus.kernel_calc_fin_o;
        o_ov   = bus.out_valid_o;
        o_done = bus.layer_done_o;
        o_busy = bus.busy_o;

        if (ab) begin
            model_clear();
        end else if (!m_active) begin
            if (st) begin
                model_clear();
                m_active   = 1'b1;
                m_next_acc = t + 1;
            end
        end else begin
            if (e_kcf) begin
                m_last_acc = t;
                m_rows++;
                if (m_rows % K == 0) m_out_at = t + L + 1;
                else                 m_next_acc = t + L + 1;
            end
            if (e_ov && ordy) begin
                $display("pooled row accepted: idx=%0d cycle=%0d", e_idx, t);
                m_out_at = -1;
                if (m_rows == K * O) m_done_at = t + 1;
                else                 m_next_acc = t + 1;
            end
            if (e_done) begin
                $display("layer done: cycle=%0d", t);
                m_active = 1'b0;
            end
        end
        t++;
    endtask

    // Full map from IDLE. mode 0: clean, 1: in_valid gap before row 2,
    // 2: out_ready stall on pooled row 0, 3: stray start pulses while busy.
    task automatic run_map(input int mode);
        int rel;
        ov_rel.delete();
        done_rel = -1; idle_rel = -1; kcf_cnt = 0; stall = 0;
        ab = 0; iv = 1; ordy = 1; st = 1;
        step();
        st = 0;
        t0 = t - 1;
        for (int i = 0; i < 40 * P && idle_rel < 0; i++) begin
            iv = 1; ordy = 1; st = 0;
            if (mode == 1 && m_rows == 2 && stall < 3) begin
                iv = 0;
                if (m_out_at < 0 && t >= m_next_acc) stall++;
            end
            if (mode == 2 && m_rows == K && m_out_at >= 0 && t >= m_out_at && stall < 4) begin
                ordy = 0;
                stall++;
            end
            if (mode == 3 && (i % 5) == 2) st = 1;
            step();
            rel = t - 1 - t0;
            if (o_kcf) kcf_cnt++;
            if (o_ov) ov_rel.push_back(rel);
            if (o_done) done_rel = rel;
            if (!o_busy && idle_rel < 0) idle_rel = rel;
        end
        st = 0;
        check_val("map_reached_idle", int'(idle_rel >= 0), 1);
        check_val("map_kcf_count", kcf_cnt, K * O);
    endtask

    // Asynchronous reset raised between clock edges.
    task automatic mid_reset(input string tag);
        st = 0; ab = 0; iv = 0; ordy = 0;
        bus.start_i = 0; bus.abort_i = 0; bus.in_valid_i = 0; bus.out_ready_i = 0;
        #2 rst = 1'b1;
        #1;
        check_all_zero(tag);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        t++;
    endtask

    initial begin
        rst = 1'b1;
        st = 0; ab = 0; iv = 0; ordy = 0;
        bus.start_i = 0; bus.abort_i = 0; bus.in_valid_i = 0; bus.out_ready_i = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // idle cycles with stray handshake inputs
        iv = 1; ordy = 1;
        repeat (3) step();

        // 1: clean map timing
        run_map(0);
        check_val("t1_out_count", ov_rel.size(), O);
        for (int i = 0; i < O; i++) check_val("t1_out_cycle", ov_rel[i], P * (i + 1));
        check_val("t1_done_cycle", done_rel, P * O + 1);
        check_val("t1_idle_cycle", idle_rel, P * O + 2);

        // 2: upstream gap before row 2
        run_map(1);
        check_val("t2_out0_cycle", ov_rel[0], P);
        check_val("t2_out1_cycle", ov_rel[1], 2 * P + 3);
        check_val("t2_done_cycle", done_rel, P * O + 1 + 3);

        // 3: downstream stall on pooled row 0
        run_map(2);
        check_val("t3_out_cycles", ov_rel.size(), O + 4);
        check_val("t3_stall_end", ov_rel[4], P + 4);
        check_val("t3_done_cycle", done_rel, P * O + 1 + 4);

        // 4: abort while computing the fourth row, then a clean map
        ab = 0; iv = 1; ordy = 1; st = 1;
        step();
        st = 0;
        for (int i = 0; i < 20 * P && !(m_rows == 4 && t == m_last_acc + 1); i++) step();
        ab = 1;
        step();
        ab = 0;
        step();
        check_val("t4_abort_idle", o_busy, 0);
        check_val("t4_abort_no_out", o_ov, 0);
        run_map(0);
        check_val("t4_done_cycle", done_rel, P * O + 1);

        // 5: start while busy ignored; abort+start in IDLE ignored
        run_map(3);
        check_val("t5_done_cycle", done_rel, P * O + 1);
        st = 1; ab = 1;
        step();
        st = 0; ab = 0;
        step();
        check_val("t5_abort_start_idle", o_busy, 0);

        // 6: reset while a pooled row is held in OUTPUT
        ab = 0; iv = 1; ordy = 0; st = 1;
        step();
        st = 0;
        for (int i = 0; i < 20 * P && !(m_out_at >= 0 && t > m_out_at); i++) step();
        check_val("t6_in_output", o_ov, 1);
        mid_reset("t6_rst");
        run_map(0);
        check_val("t6_done_cycle", done_rel, P * O + 1);

        // randomized traffic with occasional start/abort
        for (int i = 0; i < 3000; i++) begin
            st   = ($urandom_range(0, 9) == 0);
            ab   = ($urandom_range(0, 79) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
